// File: rtl/fp_operand_sequencer_pkg.sv
// Shared types and the operand table for the FP adder stimulus sequencer.
// Each table entry packs {A, B} as two single-precision words.
package fp_operand_sequencer_pkg;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_SHOW = 1'b1
    } seq_state_e;

    localparam logic [63:0] FP_VEC_0 = {32'h2ac49214, 32'h6ac49214};
    localparam logic [63:0] FP_VEC_1 = {32'h3f800000, 32'h3f800000};
    localparam logic [63:0] FP_VEC_2 = {32'h40400000, 32'hc0400000};
    localparam logic [63:0] FP_VEC_3 = {32'h7f7fffff, 32'h7f7fffff};
    localparam logic [63:0] FP_VEC_4 = {32'h3fc00000, 32'h40200000};
    localparam logic [63:0] FP_VEC_5 = {32'h00000000, 32'h80000000};
    localparam logic [63:0] FP_VEC_6 = {32'h7f800000, 32'hff800000};
    localparam logic [63:0] FP_VEC_7 = {32'h42280000, 32'hc1200000};

    // Indices past the defined entries read as a zero operand pair.
    function automatic logic [63:0] fp_vector(input logic [31:0] idx);
        case (idx)
            32'd0:   return FP_VEC_0;
            32'd1:   return FP_VEC_1;
            32'd2:   return FP_VEC_2;
            32'd3:   return FP_VEC_3;
            32'd4:   return FP_VEC_4;
            32'd5:   return FP_VEC_5;
            32'd6:   return FP_VEC_6;
            32'd7:   return FP_VEC_7;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/fp_operand_sequencer_button_debouncer.sv
// Push-button front end: 2-flop synchronizer, stable-sample debouncer and
// a single-cycle pulse on each rising edge of the debounced level.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_prev_q <= level_q;
            // Any sample agreeing with the current level restarts the run.
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/fp_operand_sequencer.sv
// Steps through a table of operand pairs on a debounced button, drives them
// to the FP adder, waits out its latency and holds the captured result.
module fp_operand_sequencer
    import fp_operand_sequencer_pkg::*;
#(
    parameter int unsigned NUM_VECTORS     = 8,
    parameter int unsigned PIPE_LATENCY    = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned IDX_W           = $clog2(NUM_VECTORS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_next,
    output logic [31:0]      reg_A,
    output logic [31:0]      reg_B,
    input  logic [31:0]      fp_result,
    output logic [31:0]      result,
    output logic             result_valid,
    output logic [IDX_W-1:0] vec_index
);

    localparam int unsigned CNT_W = $clog2(PIPE_LATENCY + 1);
    localparam logic [63:0] VEC_RESET = fp_vector(32'd0);

    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] vec_idx_q;
    logic [IDX_W-1:0] vec_idx_d;
    logic [63:0]      vec_d;
    logic [31:0]      reg_a_q;
    logic [31:0]      reg_b_q;
    logic [31:0]      result_q;
    logic             valid_q;
    logic             press;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_next (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_next),
        .press_o(press)
    );

    // NUM_VECTORS is a power of two, so the natural wrap of the index suffices.
    assign vec_idx_d = vec_idx_q + IDX_W'(1);
    assign vec_d     = fp_vector(32'(vec_idx_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_WAIT;
            cnt_q     <= CNT_W'(PIPE_LATENCY);
            vec_idx_q <= '0;
            reg_a_q   <= VEC_RESET[63:32];
            reg_b_q   <= VEC_RESET[31:0];
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        result_q <= fp_result;
                        valid_q  <= 1'b1;
                        state_q  <= ST_SHOW;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (press) begin
                        vec_idx_q <= vec_idx_d;
                        reg_a_q   <= vec_d[63:32];
                        reg_b_q   <= vec_d[31:0];
                        valid_q   <= 1'b0;
                        cnt_q     <= CNT_W'(PIPE_LATENCY);
                        state_q   <= ST_WAIT;
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    assign reg_A        = reg_a_q;
    assign reg_B        = reg_b_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign vec_index    = vec_idx_q;

endmodule
